// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO responder.
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_DATA_RD,
    S_DATA_WR
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam logic [15:0] REG0_RESET = 16'h1140;
  localparam logic [15:0] REG1_RESET = 16'h796D;

  // Power-on contents of one register; the ID registers come from the top's parameters.
  function automatic logic [15:0] reset_value(input logic [4:0] idx,
                                              input logic [15:0] id1,
                                              input logic [15:0] id2);
    case (idx)
      5'd0:    reset_value = REG0_RESET;
      5'd1:    reset_value = REG1_RESET;
      5'd2:    reset_value = id1;
      5'd3:    reset_value = id2;
      default: reset_value = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/mdio_regfile.sv
// 32 x 16 management register file with write protection on regs 1-3
// and a software reset through reg0 bit 15.
module mdio_regfile import mdio_pkg::*; #(
  parameter logic [15:0] PHY_ID1 = 16'h0362,
  parameter logic [15:0] PHY_ID2 = 16'h5E62
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_addr,
  output logic [15:0] rd_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [15:0] wr_data
);

  logic [15:0] mem [32];
  logic        reload;

  assign reload = wr_en && (wr_addr == 5'd0) && wr_data[15];

  // reg0[15] is never stored, so it always reads back 0.
  always_ff @(posedge clk) begin
    if (rst || reload) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] <= reset_value(5'(i), PHY_ID1, PHY_ID2);
      end
    end else if (wr_en && !(wr_addr inside {5'd1, 5'd2, 5'd3})) begin
      mem[wr_addr] <= (wr_addr == 5'd0) ? {1'b0, wr_data[14:0]} : wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder: oversamples MDC/MDIO in the clk domain, decodes
// frames addressed to phy_addr and serves reads/writes of the register file.
module mdio_responder import mdio_pkg::*; #(
  parameter logic [15:0] PHY_ID1      = 16'h0362,
  parameter logic [15:0] PHY_ID2      = 16'h5E62,
  parameter int          PREAMBLE_LEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] phy_addr,
  input  logic       mdc_i,
  input  logic       mdio_i,
  output logic       mdio_o,
  output logic       mdio_t,
  output logic       busy,
  output logic       frame_err
);

  localparam int CW = $clog2(PREAMBLE_LEN + 1);
  localparam logic [CW-1:0] PRE_MAX = CW'(PREAMBLE_LEN);

  logic mdc_s1, mdc_s2, mdc_prev;
  logic mdio_s1, mdio_s2;
  logic mre, bit_in;

  state_t        state;
  logic [4:0]    bit_cnt;
  logic [CW-1:0] ones_cnt;
  logic [1:0]    op;
  logic [4:0]    phy_sr;
  logic [4:0]    reg_sr;
  logic [15:0]   rd_sr;
  logic [15:0]   wr_sr;
  logic          wr_en;
  logic [4:0]    rd_addr;
  logic [15:0]   rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_s1   <= 1'b0;
      mdc_s2   <= 1'b0;
      mdc_prev <= 1'b0;
      mdio_s1  <= 1'b1;
      mdio_s2  <= 1'b1;
    end else begin
      mdc_s1   <= mdc_i;
      mdc_s2   <= mdc_s1;
      mdc_prev <= mdc_s2;
      mdio_s1  <= mdio_i;
      mdio_s2  <= mdio_s1;
    end
  end

  assign mre    = mdc_s2 & ~mdc_prev;
  assign bit_in = mdio_s2;

  // Address as it will be once the current REGAD bit lands, so the read
  // value can be latched on the final REGAD sample.
  assign rd_addr = {reg_sr[3:0], bit_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      ones_cnt  <= '0;
      op        <= '0;
      phy_sr    <= '0;
      reg_sr    <= '0;
      rd_sr     <= '0;
      wr_sr     <= '0;
      wr_en     <= 1'b0;
      mdio_o    <= 1'b0;
      mdio_t    <= 1'b1;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      wr_en     <= 1'b0;
      if (mre) begin
        case (state)
          S_IDLE: begin
            if (bit_in) begin
              if (ones_cnt < PRE_MAX) ones_cnt <= ones_cnt + 1'b1;
            end else if (ones_cnt >= PRE_MAX) begin
              state    <= S_ST;
              busy     <= 1'b1;
              ones_cnt <= '0;
            end else begin
              ones_cnt <= '0;
            end
          end
          S_ST: begin
            if (bit_in) begin
              state   <= S_OP;
              bit_cnt <= '0;
            end else begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              frame_err <= 1'b1;
            end
          end
          S_OP: begin
            op <= {op[0], bit_in};
            if (bit_cnt == 5'd1) begin
              bit_cnt <= '0;
              if ({op[0], bit_in} == OP_READ || {op[0], bit_in} == OP_WRITE) begin
                state <= S_PHYAD;
              end else begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                frame_err <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_PHYAD: begin
            phy_sr <= {phy_sr[3:0], bit_in};
            if (bit_cnt == 5'd4) begin
              state   <= S_REGAD;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_REGAD: begin
            reg_sr <= {reg_sr[3:0], bit_in};
            if (bit_cnt == 5'd4) begin
              rd_sr   <= rd_data;
              bit_cnt <= '0;
              // Frames for other PHYs are dropped without any bus activity.
              if (phy_sr == phy_addr) begin
                state <= S_TA;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_TA: begin
            if (bit_cnt == 5'd1) begin
              bit_cnt <= '0;
              if (op == OP_READ) begin
                mdio_t <= 1'b0;
                mdio_o <= 1'b0;
                state  <= S_DATA_RD;
              end else begin
                state <= S_DATA_WR;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_DATA_RD: begin
            if (bit_cnt == 5'd16) begin
              mdio_t <= 1'b1;
              mdio_o <= 1'b0;
              state  <= S_IDLE;
              busy   <= 1'b0;
            end else begin
              mdio_o  <= rd_sr[15];
              rd_sr   <= {rd_sr[14:0], 1'b0};
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_DATA_WR: begin
            wr_sr <= {wr_sr[14:0], bit_in};
            if (bit_cnt == 5'd15) begin
              wr_en <= 1'b1;
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  mdio_regfile #(
    .PHY_ID1(PHY_ID1),
    .PHY_ID2(PHY_ID2)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (reg_sr),
    .wr_data (wr_sr)
  );

endmodule
